dynamic_display_scan: RTL



---
 rtl/dynamic_display_scan.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dynamic_display_scan.sv
// Multiplexed 7-segment scan driver: shadow bank written by software, copied to the active
// bank at a frame boundary, with a blank interval before each digit to suppress ghosting.
module dynamic_display_scan #(
   parameter int NUM_DIGITS  = 8,
   parameter int SCAN_COUNT  = 28'h3000,
   parameter int BLANK_COUNT = 16,
   parameter int COUNT_WIDTH = 28,
   parameter int IDX_WIDTH   = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wrEnable,
   input  logic [IDX_WIDTH-1:0]  wrIndex,
   input  logic [7:0]            wrData,
   input  logic                  wrRaw,
   input  logic                  commit,
   input  logic                  enable,
   output logic [7:0]            segOut,
   output logic [NUM_DIGITS-1:0] gateOut,
   output logic                  frameStart,
   output logic                  commitPending
);

   localparam logic [COUNT_WIDTH-1:0] SCAN_LOAD  = COUNT_WIDTH'(SCAN_COUNT - 1);
   localparam logic [COUNT_WIDTH-1:0] BLANK_LOAD =
      COUNT_WIDTH'((BLANK_COUNT > 0) ? BLANK_COUNT - 1 : 0);
   localparam logic [IDX_WIDTH-1:0]   LAST_DIGIT = IDX_WIDTH'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

   typedef struct packed {
      logic       raw;
      logic [7:0] data;
   } entry_t;

   localparam entry_t BLANK_ENTRY = '{raw: 1'b1, data: 8'h00};

   state_t                 state, state_next;
   logic [IDX_WIDTH-1:0]   digit, digit_next, digit_adv;
   logic [COUNT_WIDTH-1:0] count, count_next;
   logic                   fs_next;

   entry_t shadow      [NUM_DIGITS];
   entry_t active      [NUM_DIGITS];
   entry_t active_next [NUM_DIGITS];
   entry_t sel;
   logic   copy;
   logic   wr_ok;
   logic [7:0]            seg_next;
   logic [NUM_DIGITS-1:0] gate_next;

   function automatic logic [6:0] hex_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] enc(input entry_t e);
      return e.raw ? e.data : {e.data[7], hex_seg(e.data[3:0])};
   endfunction

   // Out-of-range indices only exist when the index field is wider than the digit count.
   if (2**IDX_WIDTH > NUM_DIGITS) begin : g_idx_check
      assign wr_ok = wrEnable && (wrIndex < IDX_WIDTH'(NUM_DIGITS));
   end else begin : g_idx_full
      assign wr_ok = wrEnable;
   end

   always_comb begin
      // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
      state_next = state;
      digit_next = digit;
      count_next = count;
      fs_next    = 1'b0;
      digit_adv  = (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
      if (!enable) begin
         state_next = IDLE;
         digit_next = '0;
         count_next = '0;
      end else begin
         case (state)
            IDLE: begin
               digit_next = '0;
               fs_next    = 1'b1;
               if (BLANK_COUNT > 0) begin
                  state_next = BLANK;
                  count_next = BLANK_LOAD;
               end else begin
                  state_next = ON;
                  count_next = SCAN_LOAD;
               end
            end
            BLANK: begin
               if (count == '0) begin
                  state_next = ON;
                  count_next = SCAN_LOAD;
               end else begin
                  count_next = count - 1'b1;
               end
            end
            ON: begin
               if (count == '0) begin
                  digit_next = digit_adv;
                  fs_next    = (digit_adv == '0);
                  if (BLANK_COUNT > 0) begin
                     state_next = BLANK;
                     count_next = BLANK_LOAD;
                  end else begin
                     state_next = ON;
                     count_next = SCAN_LOAD;
                  end
               end else begin
                  count_next = count - 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Outputs are registered from next-state values so they line up with the state register.
   assign copy = frameStart & commitPending;

   always_comb begin
      sel = BLANK_ENTRY;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         active_next[i] = copy ? shadow[i] : active[i];
         if (digit_next == IDX_WIDTH'(i)) sel = active_next[i];
         gate_next[i] = !((state_next == ON) && (digit_next == IDX_WIDTH'(i)));
      end
      seg_next = (state_next == ON) ? ~enc(sel) : 8'hFF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         digit         <= '0;
         count         <= '0;
         segOut        <= 8'hFF;
         gateOut       <= '1;
         frameStart    <= 1'b0;
         commitPending <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state         <= state_next;
         digit         <= digit_next;
         count         <= count_next;
         segOut        <= seg_next;
         gateOut       <= gate_next;
         frameStart    <= fs_next;
         commitPending <= commit | (commitPending & ~copy);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: both banks are small register arrays and must come up blank, so they are reset explicitly.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow[i] <= BLANK_ENTRY;
            active[i] <= BLANK_ENTRY;
         end
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            active[i] <= active_next[i];
            if (wr_ok && (wrIndex == IDX_WIDTH'(i))) shadow[i] <= '{raw: wrRaw, data: wrData};
         end
      end
   end

endmodule
